// File: rtl/program_counter8.sv
// program_counter8: 8-bit PC register with a hardware return-address stack
module program_counter8 #(
  parameter logic [7:0] RESET_VECTOR = 8'h00,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       load,
  input  logic       call,
  input  logic       ret,
  input  logic [7:0] loadValue,
  output logic [7:0] out,
  output logic       stackEmpty,
  output logic       stackFull,
  output logic       stackError
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  logic [SPW-1:0] sp;
  logic [7:0] stack [DEPTH];
  logic [IW-1:0] wr_idx, rd_idx;
  assign stackEmpty = sp == '0;
  assign stackFull = sp == SPW'(DEPTH);
  assign wr_idx = IW'(sp);
  assign rd_idx = IW'(sp - 1'b1);
  // PC, stack pointer and sticky error update; priority ret > call > load > inc
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out <= RESET_VECTOR;
      sp <= '0;
      stackError <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= 8'h00;
    end else if (ret) begin
      if (stackEmpty) stackError <= 1'b1;
      else begin
        out <= stack[rd_idx];
        sp <= sp - 1'b1;
      end
    end else if (call) begin
      if (stackFull) stackError <= 1'b1;
      else begin
        stack[wr_idx] <= out + 8'd1;
        sp <= sp + 1'b1;
        out <= loadValue;
      end
    end else if (load) out <= loadValue;
    else if (inc) out <= out + 8'd1;
endmodule

// File: tb/tb_program_counter8.sv
// tb_program_counter8: directed self-checking bench for program_counter8
module tb_program_counter8;
  logic clk, rst_n, inc, load, call, ret;
  logic [7:0] load_value, out;
  logic stack_empty, stack_full, stack_error;
  int checks = 0;
  int errors = 0;

  program_counter8 #(.RESET_VECTOR(8'h00), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .inc(inc), .load(load), .call(call), .ret(ret),
    .loadValue(load_value), .out(out), .stackEmpty(stack_empty),
    .stackFull(stack_full), .stackError(stack_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic l, input logic i, input logic [7:0] v);
    @(negedge clk);
    ret = r; call = c; load = l; inc = i; load_value = v;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    ret = 0; call = 0; load = 0; inc = 0; load_value = 8'h00;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; inc = 0; load = 0; call = 0; ret = 0; load_value = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out, 8'h00);
    chk("rst_empty", stack_empty, 1'b1);
    chk("rst_full", stack_full, 1'b0);
    chk("rst_err", stack_error, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    step(0, 0, 0, 1, 8'h00); chk("inc1", out, 8'h01);
    step(0, 0, 0, 1, 8'h00); chk("inc2", out, 8'h02);
    step(0, 0, 0, 1, 8'h00); chk("inc3", out, 8'h03);
    chk("inc_empty", stack_empty, 1'b1);
    chk("inc_full", stack_full, 1'b0);
    chk("inc_err", stack_error, 1'b0);

    step(0, 0, 1, 0, 8'hFE); chk("load_fe", out, 8'hFE);
    step(0, 0, 0, 1, 8'h00); chk("inc_ff", out, 8'hFF);
    step(0, 0, 0, 1, 8'h00); chk("inc_wrap", out, 8'h00);
    chk("wrap_err", stack_error, 1'b0);
    step(0, 0, 0, 0, 8'h77); chk("hold", out, 8'h00);

    step(0, 0, 1, 0, 8'h10); chk("load_10", out, 8'h10);
    step(0, 1, 0, 0, 8'h40); chk("call_40", out, 8'h40);
    chk("call_nonempty", stack_empty, 1'b0);
    step(0, 1, 0, 0, 8'h80); chk("call_80", out, 8'h80);
    step(1, 0, 0, 0, 8'h00); chk("ret_41", out, 8'h41);
    step(1, 0, 0, 0, 8'h00); chk("ret_11", out, 8'h11);
    chk("ret_empty", stack_empty, 1'b1);
    chk("nest_err", stack_error, 1'b0);

    step(0, 0, 1, 0, 8'h05); chk("load_05", out, 8'h05);
    step(0, 1, 0, 0, 8'h20); chk("callf1", out, 8'h20);
    step(0, 1, 0, 0, 8'h20); chk("callf2", out, 8'h20);
    step(0, 1, 0, 0, 8'h20); chk("callf3", out, 8'h20);
    chk("callf3_full", stack_full, 1'b0);
    step(0, 1, 0, 0, 8'h20); chk("callf4", out, 8'h20);
    chk("callf4_full", stack_full, 1'b1);
    chk("callf4_err", stack_error, 1'b0);
    step(0, 1, 0, 0, 8'h99); chk("ovf_out", out, 8'h20);
    chk("ovf_err", stack_error, 1'b1);
    chk("ovf_full", stack_full, 1'b1);
    step(1, 0, 0, 0, 8'h00); chk("retf1", out, 8'h21);
    chk("retf1_full", stack_full, 1'b0);
    step(1, 0, 0, 0, 8'h00); chk("retf2", out, 8'h21);
    step(1, 0, 0, 0, 8'h00); chk("retf3", out, 8'h21);
    step(1, 0, 0, 0, 8'h00); chk("retf4", out, 8'h06);
    chk("retf4_empty", stack_empty, 1'b1);
    chk("retf4_err", stack_error, 1'b1);

    reset_pulse();
    chk("rst2_out", out, 8'h00);
    chk("rst2_err", stack_error, 1'b0);

    step(0, 0, 1, 0, 8'h33); chk("load_33", out, 8'h33);
    step(1, 0, 0, 0, 8'h00); chk("unf_out", out, 8'h33);
    chk("unf_err", stack_error, 1'b1);
    chk("unf_empty", stack_empty, 1'b1);
    step(0, 0, 0, 1, 8'h00); chk("unf_inc", out, 8'h34);
    chk("sticky_err", stack_error, 1'b1);
    reset_pulse();
    chk("rst3_err", stack_error, 1'b0);

    step(0, 0, 1, 0, 8'h54); chk("load_54", out, 8'h54);
    step(0, 1, 0, 0, 8'h10); chk("call_10", out, 8'h10);
    step(1, 1, 1, 1, 8'h99); chk("prio_out", out, 8'h55);
    chk("prio_empty", stack_empty, 1'b1);
    chk("prio_err", stack_error, 1'b0);
    step(0, 1, 1, 1, 8'h66); chk("prio_call", out, 8'h66);
    step(0, 0, 1, 1, 8'h88); chk("prio_load", out, 8'h88);
    step(1, 0, 0, 0, 8'h00); chk("prio_ret2", out, 8'h56);

    step(0, 0, 1, 0, 8'h77); chk("load_77", out, 8'h77);
    @(negedge clk);
    ret = 0; call = 1; load = 0; inc = 0; load_value = 8'hAA;
    #2 rst_n = 1'b0;
    #1;
    chk("async_out", out, 8'h00);
    chk("async_empty", stack_empty, 1'b1);
    @(posedge clk);
    #1;
    chk("async_hold", out, 8'h00);
    chk("async_hold_empty", stack_empty, 1'b1);
    @(negedge clk);
    call = 0;
    rst_n = 1'b1;
    step(0, 0, 0, 1, 8'h00); chk("post_rst_inc", out, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/program_counter8.md
Name: program_counter8

Overview:
- 8-bit program counter stage. It registers the next fetch address and provides the PC value that the 8-bit next-address mux consumes.
- It also provides a hardware return-address stack for call/return.
- Downstream, `out` drives the incrementer/branch-select mux inputs and the instruction-memory address.
- Upstream control logic issues one PC operation per cycle.

Parameters:
- RESET_VECTOR, 8'h00: value loaded into `out` on reset.
- DEPTH, 4: number of return-stack entries. Legal range is 2..8. The stack pointer width is clog2(DEPTH+1).

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- inc, input, 1: advance PC by 1.
- load, input, 1: jump; PC <= loadValue.
- call, input, 1: push return address, then PC <= loadValue.
- ret, input, 1: PC <= popped return address.
- loadValue, input, 8: jump/call target.
- out, output, 8: current PC (registered).
- stackEmpty, output, 1: high when there are 0 entries on the stack.
- stackFull, output, 1: high when there are DEPTH entries on the stack.
- stackError, output, 1: sticky overflow/underflow flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out = RESET_VECTOR, stack pointer = 0, stackError = 0.
  - stackEmpty = 1, stackFull = 0.
  - Stack entry contents are don't-care, but must not be X-propagated into `out`.
- Reset takes effect immediately on rst_n falling, even mid-operation. An operation in the same cycle as reset assertion is discarded.
- Operation priority when several controls are high: ret > call > load > inc. Only the highest-priority operation executes.
- No control high: `out` holds.
- inc: out <= out + 1, modulo 256. 8'hFF wraps to 8'h00 with no flag.
- load: out <= loadValue. Stack is untouched.
- call, stack not full:
  - stack[sp] <= out + 1 (mod 256, so a call at 8'hFF pushes 8'h00).
  - sp <= sp + 1; out <= loadValue.
- call, stack full: no push and `out` holds. stackError <= 1.
- ret, stack not empty: out <= stack[sp-1]; sp <= sp - 1.
- ret, stack empty: `out` holds, sp stays 0, stackError <= 1.
- Latency: every operation is visible on `out` the cycle after the sampling edge. No combinational path from any input to any output.
- stackEmpty and stackFull are decoded from the registered sp. They reflect the post-edge state in the same cycle `out` updates.
- stackError is sticky: it clears only on reset. A legal operation never clears it.
- Back-to-back call then ret returns exactly the pushed address. Nested calls unwind in LIFO order.
- The stack pointer never exceeds DEPTH or goes below 0 under any input sequence.

Test Plan:
- Reset then 3 cycles of inc -> out: 00, 01, 02, 03. stackEmpty=1, stackFull=0, stackError=0.
- load loadValue=8'hFE, then inc, inc -> out: FE, FF, 00 (wrap); stackError stays 0.
- From out=8'h10: call target 8'h40, then call target 8'h80, then ret, then ret.
  - out sequence: 40, 80, 41, 11.
  - stackEmpty is 0 after the first call and 1 after the final ret.
- With DEPTH=4, five consecutive calls to 8'h20 from out=8'h05:
  - First four push 06, 21, 21, 21; stackFull=1 after the fourth.
  - Fifth call: out holds 8'h20, stackError=1.
  - Four rets then return 21, 21, 21, 06.
- Empty stack, ret with out=8'h33 -> out holds 33, stackError=1. A subsequent inc gives 34 and stackError stays 1 until rst_n pulses low.
- Same cycle: ret=1, call=1, load=1, inc=1 with one entry (8'h55) on the stack -> out=55 and stack empty (ret wins).
- Assert rst_n low asynchronously between edges during a call -> out=RESET_VECTOR immediately and stack empty.
